// File: rtl/game_pkg.sv
// Types and helpers shared by the recorder, playback and response blocks.
// Covers the recorder FSM states, the note and level widths, and a one-hot test.
package game_pkg;

  localparam int NOTE_W  = 4;
  localparam int LEVEL_W = 32;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WAIT_PRESS   = 3'd1,
    WAIT_RELEASE = 3'd2,
    DONE         = 3'd3
  } state_e;

  function automatic logic is_one_hot(input logic [NOTE_W-1:0] v);
    return (v != '0) && ((v & (v - NOTE_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchronizer plus stability counter for a vector of active-high keys.
// The output takes the synchronized value once it has held for DEBOUNCE_CYCLES cycles.
module key_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] keys_raw,
  output logic [WIDTH-1:0] keys
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] meta_q, sync_q;
  logic [WIDTH-1:0] keys_q, keys_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q is how many cycles sync_q has held its current value, saturating at CNT_MAX.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    cnt_d  = cnt_q;
    keys_d = keys_q;
    if (meta_q != sync_q) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
    if (cnt_q == CNT_MAX) begin
      keys_d = sync_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      keys_q <= '0;
      cnt_q  <= '0;
    end else begin
      meta_q <= keys_raw;
      sync_q <= meta_q;
      keys_q <= keys_d;
      cnt_q  <= cnt_d;
    end
  end

  assign keys = keys_q;

endmodule

// File: rtl/sequence_recorder.sv
// Records a player-entered note sequence from the push-buttons.
// The result is packed as a level word (first note in [31:28]) plus a note count.
module sequence_recorder
  import game_pkg::*;
#(
  parameter int MAX_NOTES       = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TIMEOUT_CYCLES  = 100000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_record,
  input  logic               finish_record,
  input  logic               consume,
  input  logic [NOTE_W-1:0]  keys_n,
  output logic [LEVEL_W-1:0] level_data,
  output logic [3:0]         level_length,
  output logic               level_valid,
  output logic               recording,
  output logic               note_captured,
  output logic [NOTE_W-1:0]  captured_note,
  output logic               note_error,
  output logic [2:0]         state_out
);

  localparam logic [3:0]  MAX_LEN  = 4'(MAX_NOTES);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [NOTE_W-1:0] keys;

  key_debouncer #(
    .WIDTH          (NOTE_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk     (clk),
    .reset   (reset),
    .keys_raw(~keys_n),
    .keys    (keys)
  );

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] data_q, data_d;
  logic [3:0]         len_q, len_d;
  logic [31:0]        tmo_q, tmo_d;
  logic               pend_q, pend_d;
  logic               cap_q, cap_d;
  logic [NOTE_W-1:0]  note_q, note_d;
  logic               err_q, err_d;

  logic [2:0] nib_idx;
  logic       has_notes;

  assign nib_idx   = 3'(4'd7 - len_q);
  assign has_notes = (len_q != 4'd0);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    len_d   = len_q;
    tmo_d   = tmo_q;
    pend_d  = pend_q;
    cap_d   = 1'b0;
    note_d  = note_q;
    err_d   = 1'b0;

    if (start_record) begin
      state_d = WAIT_PRESS;
      data_d  = '0;
      len_d   = 4'd0;
      tmo_d   = 32'd0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        WAIT_PRESS: begin
          if (keys != '0) begin
            if (is_one_hot(keys)) begin
              data_d[{nib_idx, 2'b00} +: NOTE_W] = keys;
              len_d  = len_q + 4'd1;
              cap_d  = 1'b1;
              note_d = keys;
            end else begin
              err_d = 1'b1;
            end
            pend_d  = finish_record;
            state_d = WAIT_RELEASE;
          end else if (finish_record) begin
            state_d = has_notes ? DONE : IDLE;
          end else if (has_notes) begin
            if (tmo_q >= TMO_LAST) begin
              state_d = DONE;
            end else begin
              tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + 32'd1;
            end
          end
        end
        WAIT_RELEASE: begin
          pend_d = pend_q | finish_record;
          if (keys == '0) begin
            // A finish seen during the press is honoured only now, after release.
            pend_d = 1'b0;
            if (pend_q || finish_record) begin
              state_d = has_notes ? DONE : IDLE;
            end else if (len_q == MAX_LEN) begin
              state_d = DONE;
            end else begin
              state_d = WAIT_PRESS;
              tmo_d   = 32'd0;
            end
          end
        end
        DONE: begin
          if (consume) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      len_q   <= 4'd0;
      tmo_q   <= 32'd0;
      pend_q  <= 1'b0;
      cap_q   <= 1'b0;
      note_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
      pend_q  <= pend_d;
      cap_q   <= cap_d;
      note_q  <= note_d;
      err_q   <= err_d;
    end
  end

  assign level_data    = data_q;
  assign level_length  = len_q;
  assign level_valid   = (state_q == DONE);
  assign recording     = (state_q == WAIT_PRESS) || (state_q == WAIT_RELEASE);
  assign note_captured = cap_q;
  assign captured_note = note_q;
  assign note_error    = err_q;
  assign state_out     = state_q;

endmodule

// File: tb/tb_sequence_recorder.sv
// Directed bench for sequence_recorder with a note-list model checked every cycle.
// Scenarios: basic record, bounce, chord, full buffer, timeout, empty finish, reset/priority.
module tb_sequence_recorder;

  localparam int MAXN = 8;
  localparam int DEB  = 4;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_record = 1'b0;
  logic        finish_record = 1'b0;
  logic        consume = 1'b0;
  logic [3:0]  keys_n = 4'hF;
  logic [31:0] level_data;
  logic [3:0]  level_length;
  logic        level_valid;
  logic        recording;
  logic        note_captured;
  logic [3:0]  captured_note;
  logic        note_error;
  logic [2:0]  state_out;

  sequence_recorder #(
    .MAX_NOTES      (MAXN),
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_record (start_record),
    .finish_record(finish_record),
    .consume      (consume),
    .keys_n       (keys_n),
    .level_data   (level_data),
    .level_length (level_length),
    .level_valid  (level_valid),
    .recording    (recording),
    .note_captured(note_captured),
    .captured_note(captured_note),
    .note_error   (note_error),
    .state_out    (state_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cap_cnt  = 0;
  int err_cnt  = 0;

  // Model: the notes the player is expected to enter, and the level built from them so far.
  logic [3:0]  exp_notes[$];
  logic [31:0] model_data = 32'd0;
  int          model_len  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset || start_record) begin
      model_data = 32'd0;
      model_len  = 0;
    end
  end

  always @(negedge clk) begin : compare
    logic [3:0] e;
    if (!reset) begin
      if (note_captured) begin
        cap_cnt++;
        check("capture_expected", 32'(exp_notes.size() != 0), 32'd1);
        if (exp_notes.size() != 0) begin
          e = exp_notes.pop_front();
          check("captured_note", 32'(captured_note), 32'(e));
          model_data = model_data | (32'(e) << (28 - 4 * model_len));
          model_len++;
        end
      end
      if (note_error) err_cnt++;
      check("level_length", 32'(level_length), 32'(model_len));
      check("level_data", level_data, model_data);
      check("level_valid", 32'(level_valid), 32'(state_out == 3'd3));
      check("recording", 32'(recording), 32'(state_out == 3'd1 || state_out == 3'd2));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_record = 1'b1; tick(1); start_record = 1'b0;
  endtask

  task automatic pulse_finish();
    finish_record = 1'b1; tick(1); finish_record = 1'b0;
  endtask

  task automatic pulse_consume();
    consume = 1'b1; tick(1); consume = 1'b0;
  endtask

  task automatic press(input logic [3:0] mask, input bit expect_capture);
    if (expect_capture) exp_notes.push_back(mask);
    keys_n = ~mask;
    tick(10);
    keys_n = 4'hF;
    tick(10);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, level_data, 32'd0);
    check({tag, "_length"}, 32'(level_length), 32'd0);
    check({tag, "_valid"}, 32'(level_valid), 32'd0);
    check({tag, "_recording"}, 32'(recording), 32'd0);
    check({tag, "_captured"}, 32'(note_captured), 32'd0);
    check({tag, "_note"}, 32'(captured_note), 32'd0);
    check({tag, "_error"}, 32'(note_error), 32'd0);
    check({tag, "_state"}, 32'(state_out), 32'd0);
  endtask

  initial begin
    int base;
    tick(3);
    reset = 1'b0;
    tick(2);
    check_all_zero("reset");

    // Basic record: key0, key2, key1 then finish.
    base = cap_cnt;
    pulse_start();
    press(4'b0001, 1'b1);
    press(4'b0100, 1'b1);
    press(4'b0010, 1'b1);
    pulse_finish();
    tick(2);
    check("basic_state", 32'(state_out), 32'd3);
    check("basic_valid", 32'(level_valid), 32'd1);
    check("basic_data", level_data, 32'h1420_0000);
    check("basic_length", 32'(level_length), 32'd3);
    check("basic_note", 32'(captured_note), 32'h2);
    check("basic_captures", 32'(cap_cnt - base), 32'd3);
    pulse_consume();
    check("consume_state", 32'(state_out), 32'd0);
    check("consume_valid", 32'(level_valid), 32'd0);
    check("consume_data_held", level_data, 32'h1420_0000);

    // Bounce: 2-cycle chatter on key3, then a clean hold.
    base = cap_cnt;
    pulse_start();
    exp_notes.push_back(4'b1000);
    for (int i = 0; i < 5; i++) begin
      keys_n = 4'b0111; tick(2);
      keys_n = 4'hF;    tick(2);
    end
    keys_n = 4'b0111; tick(10);
    keys_n = 4'hF;    tick(10);
    check("bounce_captures", 32'(cap_cnt - base), 32'd1);
    check("bounce_nibble", 32'(level_data[31:28]), 32'h8);
    check("bounce_length", 32'(level_length), 32'd1);
    pulse_finish();
    tick(1);
    pulse_consume();

    // Chord rejection.
    base = err_cnt;
    pulse_start();
    press(4'b0011, 1'b0);
    press(4'b0010, 1'b1);
    check("chord_errors", 32'(err_cnt - base), 32'd1);
    check("chord_data", level_data, 32'h2000_0000);
    check("chord_length", 32'(level_length), 32'd1);
    pulse_finish();
    tick(1);
    pulse_consume();

    // Full buffer: eight presses finish on their own; a ninth is ignored.
    pulse_start();
    for (int i = 0; i < MAXN; i++) press(4'b0001, 1'b1);
    check("full_state", 32'(state_out), 32'd3);
    check("full_data", level_data, 32'h1111_1111);
    check("full_length", 32'(level_length), 32'd8);
    press(4'b0001, 1'b0);
    check("ninth_state", 32'(state_out), 32'd3);
    check("ninth_length", 32'(level_length), 32'd8);
    pulse_consume();
    check("full_consumed", 32'(state_out), 32'd0);

    // Timeout after one note.
    pulse_start();
    press(4'b0001, 1'b1);
    tick(50);
    check("timeout_not_yet", 32'(state_out), 32'd1);
    tick(30);
    check("timeout_state", 32'(state_out), 32'd3);
    check("timeout_length", 32'(level_length), 32'd1);
    pulse_consume();

    // Empty finish returns to IDLE.
    pulse_start();
    pulse_finish();
    check("empty_state", 32'(state_out), 32'd0);
    check("empty_valid", 32'(level_valid), 32'd0);
    check("empty_length", 32'(level_length), 32'd0);

    // Reset mid-recording with key2 held.
    pulse_start();
    exp_notes.push_back(4'b0100);
    keys_n = 4'b1011;
    tick(10);
    reset = 1'b1;
    tick(2);
    check_all_zero("in_reset");
    keys_n = 4'hF;
    tick(3);
    reset = 1'b0;
    tick(10);
    check_all_zero("after_reset");

    // start_record beats consume in DONE.
    pulse_start();
    press(4'b0001, 1'b1);
    pulse_finish();
    check("prio_done", 32'(state_out), 32'd3);
    start_record = 1'b1;
    consume = 1'b1;
    tick(1);
    start_record = 1'b0;
    consume = 1'b0;
    check("prio_state", 32'(state_out), 32'd1);
    check("prio_length", 32'(level_length), 32'd0);
    check("prio_data", level_data, 32'd0);
    check("prio_valid", 32'(level_valid), 32'd0);
    pulse_finish();
    check("prio_idle", 32'(state_out), 32'd0);

    check("all_expected_captured", 32'(exp_notes.size()), 32'd0);
    check("total_errors", 32'(err_cnt), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
